// File: rtl/pico_pkg.sv
// -----------------------------------------------------------------------------
// pico_pkg
// Shared types and defaults for the picoMIPS I/O controller slice.
//   io_state_t : wait-sequencer states (run / waiting for sw8 / wait completed)
//   N_DEF      : default datapath, switch and display width
//   DEB_DEF    : default number of stable cycles before filtered sw8 changes
// -----------------------------------------------------------------------------
package pico_pkg;

   localparam int N_DEF   = 8;
   localparam int DEB_DEF = 4;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } io_state_t;

endpackage

// File: rtl/pico_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// pico_io_ctrl_if
// Decoder-side bundle of the picoMIPS I/O controller.
//   wait_req / wait_level : current instruction waits for filtered sw8 == level
//   disp_we / disp_data   : display register write
//   stall                 : hold PC and register-file write
//   done                  : one-cycle pulse after a wait completes
//   sw_value              : switch snapshot taken when the wait completed
//   display               : display register contents
// master = decoder/core side, slave = pico_io_ctrl.
// -----------------------------------------------------------------------------
interface pico_io_ctrl_if
   import pico_pkg::*;
#(
   parameter int N = N_DEF
);

   logic         wait_req;
   logic         wait_level;
   logic         disp_we;
   logic [N-1:0] disp_data;
   logic         stall;
   logic         done;
   logic [N-1:0] sw_value;
   logic [N-1:0] display;

   modport master (
      output wait_req, wait_level, disp_we, disp_data,
      input  stall, done, sw_value, display
   );

   modport slave (
      input  wait_req, wait_level, disp_we, disp_data,
      output stall, done, sw_value, display
   );

endinterface

// File: rtl/pico_sw_debounce.sv
// -----------------------------------------------------------------------------
// pico_sw_debounce
// Two-flop synchroniser for the asynchronous sw8 handshake switch, followed
// by an optional stability filter.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   i_sw8    : raw switch (asynchronous to clk)
//   o_sw8_f  : synchronised (and, in the board build, debounced) sw8
// Build option PICO_DEBOUNCE_EN: when defined, o_sw8_f only follows the
// synchronised switch after DEB_CYCLES consecutive differing cycles; when
// undefined it is the synchronised switch itself, so 1-cycle pulses pass.
// -----------------------------------------------------------------------------
module pico_sw_debounce
   import pico_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic i_sw8,
   output logic o_sw8_f
);

   if (DEB_CYCLES < 2) begin : g_deb_cycles_check
      $error("pico_sw_debounce: DEB_CYCLES must be at least 2");
   end

   // r_sync[1] is the synchronised switch; r_sync[0] absorbs metastability.
   logic [1:0] r_sync;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values, which is what makes the two stages a pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[0], i_sw8};
   end

`ifdef PICO_DEBOUNCE_EN
   localparam int              CW       = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_sw8_f;

   // Counter measures how long the synchronised input has disagreed with the
   // filtered value; it tops out at CNT_LAST, so it never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_sw8_f <= 1'b0;
      end else if (r_sync[1] == r_sw8_f) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_sw8_f <= r_sync[1];
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_sw8_f = r_sw8_f;
`else
   assign o_sw8_f = r_sync[1];
`endif

endmodule

// File: rtl/pico_io_ctrl.sv
// -----------------------------------------------------------------------------
// pico_io_ctrl
// picoMIPS external I/O sequencer: stalls the PC while a wait-for-sw8
// instruction is pending, snapshots the data switches when the wait
// completes and holds the display register.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   sw8      : raw handshake switch (asynchronous to clk)
//   sw_data  : raw data switches, sampled only when a wait completes
//   bus      : pico_io_ctrl_if.slave (wait_req, wait_level, disp_we,
//              disp_data in; stall, done, sw_value, display out)
// Build option PICO_DEBOUNCE_EN selects the debounced sw8 path (see
// pico_sw_debounce).
// -----------------------------------------------------------------------------
module pico_io_ctrl
   import pico_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int DEB_CYCLES = DEB_DEF
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           sw8,
   input  logic [N-1:0]   sw_data,
   pico_io_ctrl_if.slave  bus
);

   logic      w_sw8_f;
   logic      w_match;
   io_state_t r_state;
   logic      r_done;
   logic [N-1:0] r_sw_value;
   logic [N-1:0] r_display;

   pico_sw_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sw_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_sw8   (sw8),
      .o_sw8_f (w_sw8_f)
   );

   assign w_match   = (w_sw8_f == bus.wait_level);
   // Combinational so the PC is held in the very cycle the wait is decoded.
   assign bus.stall = bus.wait_req & ~w_match & ~reset;

   // Wait sequencer. A wait completes on the edge it sees wait_req with a
   // matching sw8; that edge also captures the switch bus. The cycle spent
   // in S_DONE belongs to the next instruction, which may itself be a wait.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_RUN;
         r_done     <= 1'b0;
         r_sw_value <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_RUN, S_WAIT: begin
               if (bus.wait_req && w_match) begin
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
                  r_sw_value <= sw_data;
               end else if (bus.wait_req) begin
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_DONE: begin
               r_state <= (bus.wait_req && !w_match) ? S_WAIT : S_RUN;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   // Display writes are independent of the sequencer and land even while
   // the core is stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            r_display <= '0;
      else if (bus.disp_we) r_display <= bus.disp_data;
   end

   assign bus.done     = r_done;
   assign bus.sw_value = r_sw_value;
   assign bus.display  = r_display;

endmodule

// File: tb/tb_pico_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pico_io_ctrl
// Self-checking bench for pico_io_ctrl. A cycle-level reference model derives
// the expected outputs from the externally visible rules (sw8 delayed two
// edges, optional "N equal samples" filter, one wait completion per done
// pulse); a compare process checks every output on each falling edge, and
// directed scenarios pin latencies and captured values with literals.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pico_io_ctrl;
   import pico_pkg::*;

   localparam int N   = 8;
   localparam int DEB = 4;
`ifdef PICO_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 2;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         sw8 = 1'b0;
   logic [N-1:0] sw_data = '0;
   int           n_cmp = 0;
   int           n_bad = 0;

   pico_io_ctrl_if #(.N(N)) bus ();

   pico_io_ctrl #(.N(N), .DEB_CYCLES(DEB)) dut (
      .clk     (clk),
      .reset   (reset),
      .sw8     (sw8),
      .sw_data (sw_data),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   logic         m_s1 = 1'b0, m_s2 = 1'b0, m_f = 1'b0, m_done = 1'b0;
   logic [N-1:0] m_swv = '0, m_disp = '0;
   logic         m_hist [DEB];   // earlier synchronised samples, [0] newest

   function automatic logic filt();
`ifdef PICO_DEBOUNCE_EN
      return m_f;
`else
      return m_s2;
`endif
   endfunction

   always @(posedge clk or posedge reset) begin : model_step
      logic stable;
      if (reset) begin
         m_s1 = 1'b0; m_s2 = 1'b0; m_f = 1'b0; m_done = 1'b0;
         m_swv = '0; m_disp = '0;
         for (int i = 0; i < DEB; i++) m_hist[i] = 1'b0;
      end else begin
         // A wait completes when requested and satisfied, except in the cycle
         // that is already reporting a completion.
         if (!m_done && bus.wait_req && (filt() == bus.wait_level)) begin
            m_done = 1'b1;
            m_swv  = sw_data;
         end else begin
            m_done = 1'b0;
         end
         if (bus.disp_we) m_disp = bus.disp_data;
         // Filter: adopt the synchronised value once the last DEB samples agree.
         stable = 1'b1;
         for (int i = 0; i < DEB - 1; i++) if (m_hist[i] != m_s2) stable = 1'b0;
         if (stable && (m_s2 != m_f)) m_f = m_s2;
         for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = m_s2;
         m_s2 = m_s1;
         m_s1 = sw8;
      end
   end

   always @(negedge clk) begin
      check("stall",    bus.stall,    bus.wait_req & (filt() != bus.wait_level) & ~reset);
      check("done",     bus.done,     m_done);
      check("sw_value", bus.sw_value, m_swv);
      check("display",  bus.display,  m_disp);
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int edges;
      int dones;
      bus.wait_req = 1'b1; bus.wait_level = 1'b1;
      bus.disp_we = 1'b0;  bus.disp_data = '0;

      // Reset while a wait is requested: everything quiet.
      #1 reset = 1'b1;
      #1;
      check("rst_stall", bus.stall, 0);
      check("rst_done", bus.done, 0);
      check("rst_display", bus.display, 0);
      check("rst_sw_value", bus.sw_value, 0);
      tick(); tick();
      check("rst_stall_held", bus.stall, 0);
      reset = 1'b0;
      #1 check("post_rst_stall", bus.stall, 1);

      // Wait for sw8 rising, capture 8'hA5.
      sw_data = 8'hA5;
      sw8 = 1'b1;
      edges = 0;
      while (bus.stall && edges < 50) begin tick(); edges++; end
      check("wait_latency", edges, LAT);
      tick();
      check("wait_done", bus.done, 1);
      check("wait_capture", bus.sw_value, 8'hA5);
      sw_data = 8'h00; bus.wait_req = 1'b0;
      tick();
      check("wait_done_single", bus.done, 0);
      check("wait_capture_held", bus.sw_value, 8'hA5);

      // Settle sw8 low with no wait pending.
      sw8 = 1'b0;
      repeat (12) tick();
      bus.wait_req = 1'b1; bus.wait_level = 1'b1;
      tick();
`ifdef PICO_DEBOUNCE_EN
      // 3-cycle glitch must be filtered out.
      sw8 = 1'b1;
      repeat (3) tick();
      sw8 = 1'b0;
      edges = 0; dones = 0;
      repeat (15) begin
         tick();
         edges += int'(!bus.stall);
         dones += int'(bus.done);
      end
      check("glitch_stall_low_cycles", edges, 0);
      check("glitch_dones", dones, 0);
`else
      // 1-cycle pulse passes straight through.
      sw8 = 1'b1;
      tick();
      edges = 1;
      sw8 = 1'b0;
      while (bus.stall && edges < 50) begin tick(); edges++; end
      check("pulse_latency", edges, 2);
      tick();
      dones = int'(bus.done);
      bus.wait_req = 1'b0;
      repeat (10) begin tick(); dones += int'(bus.done); end
      check("pulse_dones", dones, 1);
`endif
      bus.wait_req = 1'b0;

      // Back-to-back waits: level 1 satisfied at once, then level 0.
      sw8 = 1'b1;
      repeat (12) tick();
      sw_data = 8'h3C; bus.wait_req = 1'b1; bus.wait_level = 1'b1;
      #1 check("b2b_zero_stall", bus.stall, 0);
      tick();
      check("b2b_done1", bus.done, 1);
      check("b2b_capture1", bus.sw_value, 8'h3C);
      bus.wait_level = 1'b0; sw_data = 8'hC3; sw8 = 1'b0;
      #1 check("b2b_second_stalls", bus.stall, 1);
      edges = 0; dones = 0;
      while (bus.stall && edges < 50) begin
         tick(); edges++;
         dones += int'(bus.done);
      end
      check("b2b_latency", edges, LAT);
      check("b2b_no_extra_done", dones, 0);
      tick();
      check("b2b_done2", bus.done, 1);
      check("b2b_capture2", bus.sw_value, 8'hC3);
      bus.wait_req = 1'b0;
      tick();

      // Display write while stalled, then reset in the middle of the wait.
      bus.wait_req = 1'b1; bus.wait_level = 1'b1;
      bus.disp_we = 1'b1; bus.disp_data = 8'h7E;
      #1 check("disp_stalled", bus.stall, 1);
      tick();
      check("disp_written", bus.display, 8'h7E);
      check("disp_still_stalled", bus.stall, 1);
      bus.disp_we = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_stall", bus.stall, 0);
      check("midrst_display", bus.display, 0);
      check("midrst_sw_value", bus.sw_value, 0);
      tick(); tick();
      reset = 1'b0;
      #1;
      check("midrst_rewait", bus.stall, 1);
      check("midrst_no_done", bus.done, 0);
      bus.wait_req = 1'b0;
      tick();

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 5) == 0) sw8 = ~sw8;
         bus.wait_req = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) bus.wait_level = 1'($urandom_range(0, 1));
         sw_data = N'($urandom);
         bus.disp_we = ($urandom_range(0, 3) == 0);
         bus.disp_data = N'($urandom);
      end
      tick();
      reset = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
